mem_arbiter: RTL and testbench

- Shares the single-port synchronous system memory between three requesters:
  - the video scanout engine (video),
  - the CPU fetch unit (fetch),
  - the CPU data path (data; loads and stores issued by the control FSM).
- Video has priority, bounded by a configurable streak limit so the CPU cannot be starved.
- Fetch and data alternate round-robin when both request.
- Sits between the requesters and the memory macro; grants are issued per cycle, one access per grant.

---
 rtl/mem_arbiter.sv | 105 ++++++++++
 tb/tb_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: three-way arbiter for the shared single-port memory.
// Video first with a bounded streak; fetch and data round-robin.
module mem_arbiter #(
  parameter int ADDR_W           = 16,
  parameter int DATA_W           = 8,
  parameter int MAX_VIDEO_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n_async,
  input  logic              video_req,
  input  logic [ADDR_W-1:0] video_addr,
  output logic              video_gnt,
  output logic              video_rvalid,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = (MAX_VIDEO_STREAK > 0)
                    ? $clog2(MAX_VIDEO_STREAK + 1) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_VIDEO_STREAK);
  localparam bit CAP_EN = (MAX_VIDEO_STREAK != 0);

  typedef enum logic {RR_FETCH, RR_DATA} rr_t;

  logic [SW-1:0] streak;
  rr_t           rr_last;
  logic          video_tag;
  logic          fetch_tag;
  logic          data_tag;
  logic          cpu_req;
  logic          capped;
  logic          video_win;
  logic          fetch_win;
  logic          data_win;

  always_comb begin
    cpu_req   = fetch_req | data_req;
    capped    = CAP_EN && (streak == STREAK_MAX);
    video_win = video_req && !(cpu_req && capped);
    fetch_win = !video_win && fetch_req
             && (!data_req || rr_last == RR_DATA);
    data_win  = !video_win && data_req && !fetch_win;
  end

  // Grants are combinational, so reset has to mask them directly.
  assign video_gnt = rst_n_async & video_win;
  assign fetch_gnt = rst_n_async & fetch_win;
  assign data_gnt  = rst_n_async & data_win;

  assign mem_en    = video_gnt | fetch_gnt | data_gnt;
  assign mem_we    = data_gnt & data_we;
  assign mem_wdata = data_wdata;
  assign rdata     = mem_rdata;

  always_comb begin
    mem_addr = fetch_addr;
    unique case (1'b1)
      video_gnt: mem_addr = video_addr;
      fetch_gnt: mem_addr = fetch_addr;
      data_gnt:  mem_addr = data_addr;
      default:   mem_addr = fetch_addr;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_async) begin
    if (!rst_n_async) begin
      streak    <= '0;
      rr_last   <= RR_DATA;
      video_tag <= 1'b0;
      fetch_tag <= 1'b0;
      data_tag  <= 1'b0;
    end else begin
      video_tag <= video_gnt;
      fetch_tag <= fetch_gnt;
      data_tag  <= data_gnt & ~data_we;
      if (fetch_gnt || data_gnt)
        streak <= '0;
      else if (video_gnt && cpu_req && streak != STREAK_MAX)
        streak <= streak + 1'b1;
      if (fetch_gnt)
        rr_last <= RR_FETCH;
      else if (data_gnt)
        rr_last <= RR_DATA;
    end
  end

  assign video_rvalid = video_tag;
  assign fetch_rvalid = fetch_tag;
  assign data_rvalid  = data_tag;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table vectors, corner sequences and a random run
// against a read-return scoreboard and a grant reference model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n_async = 1'b0;
  logic        video_req = 1'b0;
  logic        fetch_req = 1'b0;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [15:0] video_addr = '0;
  logic [15:0] fetch_addr = '0;
  logic [15:0] data_addr = '0;
  logic [7:0]  data_wdata = '0;
  logic [7:0]  mem_rdata = '0;
  logic        video_gnt, video_rvalid;
  logic        fetch_gnt, fetch_rvalid;
  logic        data_gnt, data_rvalid;
  logic [7:0]  rdata, mem_wdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic        u0_vg, u0_vr, u0_fg, u0_fr, u0_dg, u0_dr;
  logic [7:0]  u0_rdata, u0_wdata;
  logic        u0_en, u0_we;
  logic [15:0] u0_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_VIDEO_STREAK(4)) dut (
    .clk(clk), .rst_n_async(rst_n_async),
    .video_req(video_req), .video_addr(video_addr),
    .video_gnt(video_gnt), .video_rvalid(video_rvalid),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_gnt(fetch_gnt), .fetch_rvalid(fetch_rvalid),
    .data_req(data_req), .data_we(data_we),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_VIDEO_STREAK(0)) u0 (
    .clk(clk), .rst_n_async(rst_n_async),
    .video_req(video_req), .video_addr(video_addr),
    .video_gnt(u0_vg), .video_rvalid(u0_vr),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_gnt(u0_fg), .fetch_rvalid(u0_fr),
    .data_req(data_req), .data_we(data_we),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(u0_dg), .data_rvalid(u0_dr),
    .rdata(u0_rdata), .mem_en(u0_en), .mem_we(u0_we),
    .mem_addr(u0_addr), .mem_wdata(u0_wdata),
    .mem_rdata(mem_rdata)
  );

  logic [7:0] mem [0:65535];
  logic [7:0] ref_mem [0:65535];

  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference arbiter: returns one-hot {video, fetch, data}.
  function automatic logic [2:0] pick(input logic v, f, d,
                                      input int st, input logic rr_d,
                                      input int mx);
    logic cpu;
    cpu = f | d;
    if (v && (!cpu || mx == 0 || st < mx)) return 3'b100;
    if (f && d) return rr_d ? 3'b010 : 3'b001;
    return {1'b0, f, d};
  endfunction

  task automatic upd(input logic [2:0] e, input logic cpu,
                     input int mx, inout int st, inout logic rr_d);
    if (e[2] && cpu && st < mx) st++;
    if (e[1]) begin st = 0; rr_d = 1'b0; end
    if (e[0]) begin st = 0; rr_d = 1'b1; end
  endtask

  typedef struct packed {
    logic [2:0] tag;
    logic [7:0] data;
  } sb_t;

  sb_t        sbq[$];
  int         st1, st0;
  logic       rr1, rr0;
  logic [2:0] lg = '0;
  logic       p_v, p_f, p_d, p_we;
  logic [15:0] p_va, p_fa, p_da;
  logic [7:0] p_wd;

  always @(negedge clk or negedge rst_n_async) begin
    sb_t         e;
    logic [2:0]  e1, e0;
    logic [15:0] ea;
    logic [7:0]  rd;
    if (!rst_n_async) begin
      sbq.delete();
      st1 = 0; st0 = 0; rr1 = 1'b1; rr0 = 1'b1; lg = '0;
      p_v = 1'b0; p_f = 1'b0; p_d = 1'b0;
    end else begin
      e = '0;
      if (sbq.size() > 0) e = sbq.pop_front();
      chk("rvalid", {video_rvalid, fetch_rvalid, data_rvalid}, e.tag);
      if (e.tag != 0) chk("rdata", rdata, e.data);
      e1 = pick(video_req, fetch_req, data_req, st1, rr1, 4);
      e0 = pick(video_req, fetch_req, data_req, st0, rr0, 0);
      chk("gnt", {video_gnt, fetch_gnt, data_gnt}, e1);
      chk("gnt_max0", {u0_vg, u0_fg, u0_dg}, e0);
      chk("mem_en", mem_en, |e1);
      if (e1 != 0) begin
        ea = e1[2] ? video_addr : (e1[1] ? fetch_addr : data_addr);
        chk("mem_addr", mem_addr, ea);
        chk("mem_we", mem_we, e1[0] & data_we);
      end
      if (e1[0] && data_we) begin
        chk("mem_wdata", mem_wdata, data_wdata);
        ref_mem[data_addr] = data_wdata;
      end
      if (p_v && video_req)
        assert (video_addr == p_va) else $error("unstable video req");
      if (p_f && fetch_req)
        assert (fetch_addr == p_fa) else $error("unstable fetch req");
      if (p_d && data_req)
        assert (data_addr == p_da && data_we == p_we
                && data_wdata == p_wd) else $error("unstable data req");
      p_v = video_req & ~video_gnt; p_va = video_addr;
      p_f = fetch_req & ~fetch_gnt; p_fa = fetch_addr;
      p_d = data_req & ~data_gnt;   p_da = data_addr;
      p_we = data_we; p_wd = data_wdata;
      rd = e1[2] ? ref_mem[video_addr]
         : (e1[1] ? ref_mem[fetch_addr] : ref_mem[data_addr]);
      sbq.push_back({e1[2], e1[1], e1[0] & ~data_we, rd});
      upd(e1, fetch_req | data_req, 4, st1, rr1);
      upd(e0, fetch_req | data_req, 0, st0, rr0);
      lg = {video_gnt, fetch_gnt, data_gnt};
    end
  end

  task automatic step(input logic v, f, d, we);
    @(posedge clk); #1;
    video_req = v; fetch_req = f; data_req = d; data_we = we;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n_async = 1'b0;
    video_req = 1'b1; fetch_req = 1'b1; data_req = 1'b1; data_we = 1'b0;
    #1;
    chk("rst gnt", {video_gnt, fetch_gnt, data_gnt}, 0);
    chk("rst rvalid", {video_rvalid, fetch_rvalid, data_rvalid}, 0);
    chk("rst mem", {mem_en, mem_we}, 0);
    repeat (2) @(posedge clk);
    #1;
    video_req = 1'b0; fetch_req = 1'b0; data_req = 1'b0;
    rst_n_async = 1'b1;
  endtask

  typedef struct {
    logic v, f, d, we;
    logic [2:0] g;
  } vec_t;

  function automatic vec_t mk(input logic v, f, d, we,
                              input logic [2:0] g);
    vec_t r;
    r.v = v; r.f = f; r.d = d; r.we = we; r.g = g;
    return r;
  endfunction

  vec_t tbl [20];

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[16'h0100] = 8'hA5;
    ref_mem[16'h0100] = 8'hA5;

    tbl[0] = mk(1'b0, 1'b1, 1'b0, 1'b0, 3'b010);
    tbl[1] = mk(1'b0, 1'b1, 1'b1, 1'b0, 3'b001);
    tbl[2] = mk(1'b0, 1'b1, 1'b1, 1'b0, 3'b010);
    tbl[3] = mk(1'b0, 1'b1, 1'b1, 1'b0, 3'b001);
    tbl[4] = mk(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    tbl[5] = mk(1'b1, 1'b0, 1'b0, 1'b0, 3'b100);
    for (int i = 6; i < 16; i++)
      tbl[i] = mk(1'b1, 1'b0, 1'b1, 1'b0,
                  (i == 10 || i == 15) ? 3'b001 : 3'b100);
    tbl[16] = mk(1'b1, 1'b1, 1'b0, 1'b0, 3'b100);
    tbl[17] = mk(1'b0, 1'b0, 1'b1, 1'b1, 3'b001);
    tbl[18] = mk(1'b1, 1'b1, 1'b1, 1'b0, 3'b100);
    tbl[19] = mk(1'b0, 1'b1, 1'b1, 1'b0, 3'b010);

    // Single fetch read after reset.
    do_reset();
    fetch_addr = 16'h0100;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("A gnt", {video_gnt, fetch_gnt, data_gnt}, 3'b010);
    chk("A addr", mem_addr, 16'h0100);
    chk("A en/we", {mem_en, mem_we}, 2'b10);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("A rvalid", {video_rvalid, fetch_rvalid, data_rvalid}, 3'b010);
    chk("A rdata", rdata, 8'hA5);

    // Grant table from a fresh reset.
    do_reset();
    video_addr = 16'h1000; fetch_addr = 16'h0100;
    data_addr = 16'h2000;  data_wdata = 8'h5A;
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].v, tbl[i].f, tbl[i].d, tbl[i].we);
      chk($sformatf("tbl%0d", i),
          {video_gnt, fetch_gnt, data_gnt}, tbl[i].g);
      if (i >= 6 && i < 16) chk($sformatf("max0 %0d", i), u0_dg, 1'b0);
    end

    // Data write then read-back.
    do_reset();
    data_addr = 16'h2000; data_wdata = 8'h3C;
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("B wr gnt", data_gnt, 1'b1);
    chk("B wr mem", {mem_en, mem_we, mem_addr, mem_wdata},
        {2'b11, 16'h2000, 8'h3C});
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("B no rvalid", data_rvalid, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("B rd gnt", {data_gnt, mem_we}, 2'b10);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("B rd rvalid", data_rvalid, 1'b1);
    chk("B rd data", rdata, 8'h3C);

    // Reset pulse while a video read is in flight.
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("C gnt N", video_gnt, 1'b1);
    @(posedge clk); #1;
    video_req = 1'b1; fetch_req = 1'b1; data_req = 1'b1;
    chk("C rvalid N+1", video_rvalid, 1'b1);
    #1 rst_n_async = 1'b0;
    #1 chk("C rvalid rst", video_rvalid, 1'b0);
    chk("C gnt rst", {video_gnt, fetch_gnt, data_gnt}, 0);
    #1 rst_n_async = 1'b1;
    @(negedge clk);
    chk("C rvalid post", video_rvalid, 1'b0);
    chk("C gnt post", video_gnt, 1'b1);
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("C streak", video_gnt, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("C rr", {video_gnt, fetch_gnt, data_gnt}, 3'b010);

    // Random traffic; held requests stay stable until granted.
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk); #1;
      if (!video_req || lg[2]) begin
        video_req = ($urandom_range(0, 9) < 6);
        video_addr = 16'($urandom_range(0, 255));
      end
      if (!fetch_req || lg[1]) begin
        fetch_req = ($urandom_range(0, 9) < 4);
        fetch_addr = 16'($urandom_range(0, 255));
      end
      if (!data_req || lg[0]) begin
        data_req = ($urandom_range(0, 9) < 4);
        data_we = 1'($urandom_range(0, 1));
        data_addr = 16'($urandom_range(0, 255));
        data_wdata = 8'($urandom);
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
